free_list_ckpt: RTL and testbench

- Superscalar successor to the single-port physical-register free list.
- Allocates up to ALLOC_W destination PRs per cycle to the decode group and accepts up to RET_W freed PRs per cycle from retire.
- Branch recovery restores the head pointer in one cycle from per-branch checkpoints, so the ROB no longer re-pushes flushed PRs.
- Sits between the D stage (rename) and the retire stage, next to the rename map table.

---
 rtl/ooo_pkg.sv | 17 +
 rtl/prefix_rank.sv | 18 +
 rtl/free_list_ckpt.sv | 106 ++++++++++
 tb/tb_free_list_ckpt.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// ooo_pkg: shared sizing, PR types and pointer helpers for the rename free list.
package ooo_pkg;
    localparam int NUM_PR   = 64;
    localparam int NUM_AR   = 32;
    localparam int ALLOC_W  = 2;
    localparam int RET_W    = 2;
    localparam int NUM_CKPT = 4;
    localparam int PRW      = $clog2(NUM_PR);
    localparam int CKW      = $clog2(NUM_CKPT);

    typedef logic [PRW-1:0] pr_t;
    typedef logic [PRW:0]   ptr_t;

    function automatic pr_t idx(input ptr_t p);
        return p[PRW-1:0];
    endfunction
endpackage

// File: rtl/prefix_rank.sv
// prefix_rank: popcount of a request vector plus each slot's exclusive prefix count.
module prefix_rank #(
    parameter int W  = 2,
    parameter int CW = $clog2(W+1)
) (
    input  logic [W-1:0]         req_i,
    output logic [CW-1:0]        cnt_o,
    output logic [W-1:0][CW-1:0] rank_o
);
    always_comb begin
        cnt_o  = '0;
        rank_o = '0;
        for (int i = 0; i < W; i++) begin
            rank_o[i] = cnt_o;
            cnt_o     = cnt_o + CW'(req_i[i]);
        end
    end
endmodule

// File: rtl/free_list_ckpt.sv
// free_list_ckpt: multi-port physical-register free list with single-cycle
// head restore from per-branch checkpoints.
module free_list_ckpt
    import ooo_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ALLOC_W-1:0]      RegDest,
    input  logic                    stall,
    output logic [ALLOC_W*PRW-1:0]  PR_new,
    output logic                    alloc_ok,
    input  logic [RET_W-1:0]        retire_reg,
    input  logic [RET_W*PRW-1:0]    PR_old,
    input  logic                    ckpt_save,
    input  logic [CKW-1:0]          ckpt_id,
    input  logic                    recover,
    input  logic [CKW-1:0]          recover_id,
    input  logic [NUM_CKPT-1:0]     ckpt_kill_mask,
    input  logic                    ckpt_release,
    input  logic [CKW-1:0]          release_id,
    output logic                    empty,
    output logic [PRW:0]            free_count,
    output logic [NUM_CKPT-1:0]     ckpt_valid,
    output logic                    err
);
    localparam int ACW = $clog2(ALLOC_W+1);
    localparam int RCW = $clog2(RET_W+1);
    localparam int XW  = PRW + 2;

    pr_t                      mem_q [NUM_PR];
    ptr_t                     ckpt_head_q [NUM_CKPT];
    ptr_t                     head_q, head_d, tail_q, tail_d, head_alloc;
    logic [NUM_CKPT-1:0]      ckpt_valid_q, ckpt_valid_d;
    logic                     err_q, err_d;
    logic [ACW-1:0]           n_alloc;
    logic [ALLOC_W-1:0][ACW-1:0] rank_a;
    logic [RCW-1:0]           n_free;
    logic [RET_W-1:0][RCW-1:0]   rank_f;
    logic                     rec_ok, save_en, ovf;

    prefix_rank #(.W(ALLOC_W), .CW(ACW)) u_alloc_rank (
        .req_i (RegDest),
        .cnt_o (n_alloc),
        .rank_o(rank_a)
    );

    prefix_rank #(.W(RET_W), .CW(RCW)) u_free_rank (
        .req_i (retire_reg),
        .cnt_o (n_free),
        .rank_o(rank_f)
    );

    assign free_count = tail_q - head_q;
    assign empty      = free_count == '0;
    assign alloc_ok   = (free_count >= ptr_t'(n_alloc)) & ~stall & ~recover;
    assign rec_ok     = ckpt_valid_q[recover_id];
    assign save_en    = ckpt_save & ~recover;
    assign ovf        = XW'(free_count) + XW'(n_free) > XW'(NUM_PR);
    assign head_alloc = alloc_ok ? head_q + ptr_t'(n_alloc) : head_q;
    assign ckpt_valid = ckpt_valid_q;
    assign err        = err_q;

    // Requesting slots pack densely from the head; idle slots just see the next entry.
    always_comb begin
        PR_new = '0;
        for (int k = 0; k < ALLOC_W; k++)
            PR_new[k*PRW +: PRW] = mem_q[idx(head_q + ptr_t'(rank_a[k]))];
    end

    always_comb begin
        head_d       = recover ? (rec_ok ? ckpt_head_q[recover_id] : head_q) : head_alloc;
        tail_d       = tail_q + ptr_t'(n_free);
        ckpt_valid_d = ckpt_valid_q;
        if (ckpt_release)
            ckpt_valid_d[release_id] = 1'b0;
        if (recover) begin
            ckpt_valid_d             = ckpt_valid_d & ~ckpt_kill_mask;
            ckpt_valid_d[recover_id] = 1'b0;
        end else if (ckpt_save) begin
            ckpt_valid_d[ckpt_id] = 1'b1;
        end
        err_d = err_q | (recover & ~rec_ok) | (save_en & ckpt_valid_q[ckpt_id]) | ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q       <= '0;
            tail_q       <= ptr_t'(NUM_PR - NUM_AR);
            ckpt_valid_q <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_PR; i++)
                mem_q[i] <= pr_t'(NUM_AR + i);
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            ckpt_valid_q <= ckpt_valid_d;
            err_q        <= err_d;
            for (int j = 0; j < RET_W; j++)
                if (retire_reg[j])
                    mem_q[idx(tail_q + ptr_t'(rank_f[j]))] <= PR_old[j*PRW +: PRW];
            // Checkpoint captures the head including this cycle's grant.
            if (save_en)
                ckpt_head_q[ckpt_id] <= head_alloc;
        end
    end
endmodule

// File: tb/tb_free_list_ckpt.sv
// tb_free_list_ckpt: directed stimulus with a queued scoreboard checked on the falling edge.
module tb_free_list_ckpt;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  RegDest;
    logic        stall;
    logic [11:0] PR_new;
    logic        alloc_ok;
    logic [1:0]  retire_reg;
    logic [11:0] PR_old;
    logic        ckpt_save;
    logic [1:0]  ckpt_id;
    logic        recover;
    logic [1:0]  recover_id;
    logic [3:0]  ckpt_kill_mask;
    logic        ckpt_release;
    logic [1:0]  release_id;
    logic        empty;
    logic [6:0]  free_count;
    logic [3:0]  ckpt_valid;
    logic        err;

    free_list_ckpt dut (
        .clk(clk), .rst(rst), .RegDest(RegDest), .stall(stall), .PR_new(PR_new),
        .alloc_ok(alloc_ok), .retire_reg(retire_reg), .PR_old(PR_old),
        .ckpt_save(ckpt_save), .ckpt_id(ckpt_id), .recover(recover),
        .recover_id(recover_id), .ckpt_kill_mask(ckpt_kill_mask),
        .ckpt_release(ckpt_release), .release_id(release_id), .empty(empty),
        .free_count(free_count), .ckpt_valid(ckpt_valid), .err(err)
    );

    always #5 clk = ~clk;

    // en bits: 0 slot0 PR, 1 slot1 PR, 2 alloc_ok, 3 free_count/empty, 4 ckpt_valid, 5 err
    typedef struct {
        string      nm;
        logic [5:0] en;
        int         p0, p1;
        logic       ok;
        int         fc;
        logic [3:0] cv;
        logic       er;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;

    task automatic cmp(input string nm, input string f, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s.%s: got %0d want %0d", nm, f, act, req);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.en[0]) cmp(e.nm, "pr0", int'(PR_new[5:0]), e.p0);
            if (e.en[1]) cmp(e.nm, "pr1", int'(PR_new[11:6]), e.p1);
            if (e.en[2]) cmp(e.nm, "alloc_ok", int'(alloc_ok), int'(e.ok));
            if (e.en[3]) begin
                cmp(e.nm, "free_count", int'(free_count), e.fc);
                cmp(e.nm, "empty", int'(empty), int'(e.fc == 0));
            end
            if (e.en[4]) cmp(e.nm, "ckpt_valid", int'(ckpt_valid), int'(e.cv));
            if (e.en[5]) cmp(e.nm, "err", int'(err), int'(e.er));
        end
    end

    task automatic chk(input string nm, input logic [5:0] en, input int p0, input int p1,
                       input logic ok, input int fc, input logic [3:0] cv, input logic er);
        exp_t e;
        e.nm = nm; e.en = en; e.p0 = p0; e.p1 = p1;
        e.ok = ok; e.fc = fc; e.cv = cv; e.er = er;
        q.push_back(e);
    endtask

    task automatic idle();
        RegDest = '0; stall = 0; retire_reg = '0; PR_old = '0;
        ckpt_save = 0; ckpt_id = '0; recover = 0; recover_id = '0;
        ckpt_kill_mask = '0; ckpt_release = 0; release_id = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        rst = 0;
        tick();
        rst = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 0;
        tick();
        tick();
        rst = 1;
        chk("reset", 6'b111001, 32, 0, 0, 32, 4'b0000, 0); tick();
        stall = 1; RegDest = 2'b11;
        chk("stall", 6'b000111, 32, 33, 0, 0, 0, 0); tick();
        RegDest = 2'b11;
        chk("alloc2", 6'b001111, 32, 33, 1, 32, 0, 0); tick();
        RegDest = 2'b10;
        chk("slot1_only", 6'b001110, 0, 34, 1, 30, 0, 0); tick();
        chk("after_one", 6'b001101, 35, 0, 1, 29, 0, 0); tick();
        for (int i = 0; i < 14; i++) begin
            RegDest = 2'b11;
            chk("fill", 6'b000111, 35 + 2*i, 36 + 2*i, 1, 0, 0, 0); tick();
        end
        RegDest = 2'b11;
        chk("short", 6'b001101, 63, 0, 0, 1, 0, 0); tick();
        RegDest = 2'b11;
        chk("hold", 6'b001101, 63, 0, 0, 1, 0, 0); tick();
        RegDest = 2'b01;
        chk("last", 6'b000101, 63, 0, 1, 0, 0, 0); tick();
        RegDest = 2'b01;
        chk("empty_deny", 6'b001100, 0, 0, 0, 0, 0, 0); tick();
        chk("empty_zero_req", 6'b000100, 0, 0, 1, 0, 0, 0); tick();

        do_reset();
        RegDest = 2'b11; ckpt_save = 1; ckpt_id = 2;
        chk("save2", 6'b010111, 32, 33, 1, 0, 4'b0000, 0); tick();
        RegDest = 2'b11; ckpt_save = 1; ckpt_id = 3;
        chk("save3", 6'b011111, 34, 35, 1, 30, 4'b0100, 0); tick();
        RegDest = 2'b11; recover = 1; recover_id = 2; ckpt_kill_mask = 4'b1000;
        chk("recover", 6'b011100, 0, 0, 0, 28, 4'b1100, 0); tick();
        chk("restored", 6'b111001, 34, 0, 0, 30, 4'b0000, 0); tick();
        ckpt_save = 1; ckpt_id = 1; tick();
        ckpt_release = 1; release_id = 1;
        chk("release", 6'b010000, 0, 0, 0, 0, 4'b0010, 0); tick();
        ckpt_release = 1; release_id = 0;
        chk("released", 6'b010000, 0, 0, 0, 0, 4'b0000, 0); tick();
        chk("release_bad", 6'b110000, 0, 0, 0, 0, 4'b0000, 0); tick();

        do_reset();
        RegDest = 2'b11; retire_reg = 2'b11; PR_old = {6'd7, 6'd5};
        chk("alloc_free", 6'b001111, 32, 33, 1, 32, 0, 0); tick();
        for (int i = 0; i < 16; i++) begin
            RegDest = 2'b11;
            chk("drain", 6'b001111, (i < 15) ? 34 + 2*i : 5, (i < 15) ? 35 + 2*i : 7,
                1, 32 - 2*i, 0, 0);
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            retire_reg = 2'b11; PR_old = {6'(2*i + 1), 6'(2*i)};
            chk("refill", 6'b001000, 0, 0, 0, 2*i, 0, 0); tick();
        end
        for (int i = 0; i < 16; i++) begin
            RegDest = 2'b11;
            chk("wrap", 6'b001111, 2*i, 2*i + 1, 1, 32 - 2*i, 0, 0); tick();
        end
        chk("wrapped", 6'b101000, 0, 0, 0, 0, 0, 0); tick();

        do_reset();
        recover = 1; recover_id = 1;
        chk("bad_recover", 6'b100100, 0, 0, 0, 0, 0, 0); tick();
        chk("bad_recover_err", 6'b101001, 32, 0, 0, 32, 0, 1); tick();
        tick();
        chk("sticky", 6'b100000, 0, 0, 0, 0, 0, 1); tick();
        do_reset();
        ckpt_save = 1; ckpt_id = 0;
        chk("err_cleared", 6'b110000, 0, 0, 0, 0, 4'b0000, 0); tick();
        ckpt_save = 1; ckpt_id = 0;
        chk("dup_first", 6'b110000, 0, 0, 0, 0, 4'b0001, 0); tick();
        chk("dup_err", 6'b110000, 0, 0, 0, 0, 4'b0001, 1); tick();

        do_reset();
        for (int i = 0; i < 16; i++) begin
            retire_reg = 2'b11; PR_old = {6'(i), 6'(i)}; tick();
        end
        retire_reg = 2'b01;
        chk("full", 6'b101000, 0, 0, 0, 64, 0, 0); tick();
        chk("overflow", 6'b100000, 0, 0, 0, 0, 0, 1); tick();

        repeat (3) @(negedge clk);
        total++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain_queue: got %0d pending want 0", q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
